// File: rtl/wave_meas_pkg.sv
// Shared constants, detector state type and saturating 8-bit helpers for wave_meas.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wave_meas_pkg;

    localparam int         ADC_W           = 8;
    localparam logic [7:0] MID_SCALE       = 8'd128;
    localparam int         SYS_CLK_HZ      = 50_000_000;

    localparam int         DEF_GATE_CYCLES = SYS_CLK_HZ;
    localparam int         DEF_CNT_W       = 27;
    localparam logic [7:0] DEF_HYST        = 8'd8;

    typedef enum logic {
        DET_LO = 1'b0,
        DET_HI = 1'b1
    } det_state_t;

    // a + b clamped to 255 instead of wrapping
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    // a - b clamped to 0 instead of wrapping
    function automatic logic [7:0] sat_sub8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} - {1'b0, b};
        return s[8] ? 8'h00 : s[7:0];
    endfunction

endpackage

// File: rtl/wave_meas_if.sv
// Bundles the sample stream, enable and measurement results of wave_meas.
// Latency: n/a (wiring only).
// Backpressure: none; samples are accepted whenever valid, results are pulsed.
interface wave_meas_if #(
    parameter int CNT_W = 27
);
    logic             meas_en;
    logic             adc_vld;
    logic [7:0]       adc_data;
    logic [CNT_W-1:0] freq_cnt;
    logic [7:0]       wave_max;
    logic [7:0]       wave_min;
    logic [7:0]       wave_vpp;
    logic             meas_valid;
    logic             sig_lost;
    logic [CNT_W-1:0] duty_cnt;

    // Sample source / result consumer side
    modport master (
        output meas_en, adc_vld, adc_data,
        input  freq_cnt, wave_max, wave_min, wave_vpp, meas_valid, sig_lost, duty_cnt
    );

    // Measurement block side
    modport slave (
        input  meas_en, adc_vld, adc_data,
        output freq_cnt, wave_max, wave_min, wave_vpp, meas_valid, sig_lost, duty_cnt
    );
endinterface

// File: rtl/wave_meas_hyst_cross_det.sv
// Two-state hysteresis crossing detector: flags a rising crossing of thr+hyst, re-arms below thr-hyst.
// Latency: rise / det_now combinational on the sample; state registered one cycle later.
// Backpressure: none; only cycles with smp_vld move the state.
module hyst_cross_det
    import wave_meas_pkg::*;
(
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       smp_vld,
    input  logic [7:0] smp_dat,
    input  logic [7:0] thr,
    input  logic [7:0] hyst,
    output det_state_t det_now,
    output logic       rise
);
    det_state_t state;
    logic [7:0] hi_lvl;
    logic [7:0] lo_lvl;
    logic       fall;

    // Band edges clamp at the rails so a threshold near 0/255 never wraps
    assign hi_lvl = sat_add8(thr, hyst);
    assign lo_lvl = sat_sub8(thr, hyst);

    // Crossing decision for the current sample; det_now is the state including it
    always_comb begin
        rise    = 1'b0;
        fall    = 1'b0;
        if (smp_vld) begin
            if (state == DET_LO && smp_dat >= hi_lvl) rise = 1'b1;
            if (state == DET_HI && smp_dat <= lo_lvl) fall = 1'b1;
        end
        det_now = state;
        if (rise) det_now = DET_HI;
        if (fall) det_now = DET_LO;
    end

    // Detector state; deliberately never cleared at window boundaries
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= DET_LO;
        else            state <= det_now;
    end
endmodule

// File: rtl/wave_meas.sv
// Gated waveform meter: per GATE_CYCLES window reports rising crossings, max, min, vpp (duty with MEAS_DUTY_EN).
// Latency: results and the one-cycle meas_valid appear the cycle after the last window cycle.
// Backpressure: none; samples with adc_vld=1 while meas_en=1 are always taken.
module wave_meas
    import wave_meas_pkg::*;
#(
    parameter int         GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int         CNT_W       = DEF_CNT_W,
    parameter logic [7:0] HYST        = DEF_HYST
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    wave_meas_if.slave   mif
);
    logic [CNT_W-1:0] gate_cnt;
    logic             win_end;
    logic             smp_acc;

    logic [7:0]       thr;
    logic [7:0]       acc_max,   nxt_max;
    logic [7:0]       acc_min,   nxt_min;
    logic [CNT_W-1:0] acc_cross, nxt_cross;
    logic             acc_any,   nxt_any;
    logic [8:0]       mid_sum;

    logic [CNT_W-1:0] freq_q;
    logic [7:0]       max_q, min_q, vpp_q;
    logic             valid_q, lost_q;

    det_state_t       det_now;
    logic             rise;

    assign smp_acc = mif.adc_vld && mif.meas_en;
    assign win_end = mif.meas_en && (gate_cnt == CNT_W'(GATE_CYCLES - 1));

    hyst_cross_det u_det (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .smp_vld   (smp_acc),
        .smp_dat   (mif.adc_data),
        .thr       (thr),
        .hyst      (HYST),
        .det_now   (det_now),
        .rise      (rise)
    );

    // Window timer: free-runs while enabled, parked at 0 while disabled
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)    gate_cnt <= '0;
        else if (!mif.meas_en || win_end) gate_cnt <= '0;
        else               gate_cnt <= gate_cnt + CNT_W'(1);
    end

    // Accumulator values including this cycle's sample, so the last window sample is counted
    always_comb begin
        nxt_max   = acc_max;
        nxt_min   = acc_min;
        nxt_cross = acc_cross;
        nxt_any   = acc_any;
        if (smp_acc) begin
            nxt_any = 1'b1;
            if (mif.adc_data > acc_max) nxt_max = mif.adc_data;
            if (mif.adc_data < acc_min) nxt_min = mif.adc_data;
        end
        if (rise && acc_cross != '1) nxt_cross = acc_cross + CNT_W'(1);
    end

    assign mid_sum = {1'b0, nxt_max} + {1'b0, nxt_min};

    // Accumulators restart at window end and whenever measurement is disabled
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n || 1'b0) begin
            acc_max   <= 8'd0;
            acc_min   <= 8'd255;
            acc_cross <= '0;
            acc_any   <= 1'b0;
        end else if (!mif.meas_en || win_end) begin
            acc_max   <= 8'd0;
            acc_min   <= 8'd255;
            acc_cross <= '0;
            acc_any   <= 1'b0;
        end else begin
            acc_max   <= nxt_max;
            acc_min   <= nxt_min;
            acc_cross <= nxt_cross;
            acc_any   <= nxt_any;
        end
    end

    // Result latch and threshold update at window end; everything else holds
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            thr     <= MID_SCALE;
            freq_q  <= '0;
            max_q   <= 8'd0;
            min_q   <= 8'd0;
            vpp_q   <= 8'd0;
            lost_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= win_end;
            if (win_end) begin
                if (nxt_any) begin
                    freq_q <= nxt_cross;
                    max_q  <= nxt_max;
                    min_q  <= nxt_min;
                    vpp_q  <= nxt_max - nxt_min;
                    lost_q <= (nxt_cross == '0);
                    thr    <= mid_sum[8:1];
                end else begin
                    freq_q <= '0;
                    max_q  <= 8'd0;
                    min_q  <= 8'd0;
                    vpp_q  <= 8'd0;
                    lost_q <= 1'b1;
                end
            end
        end
    end

    assign mif.freq_cnt   = freq_q;
    assign mif.wave_max   = max_q;
    assign mif.wave_min   = min_q;
    assign mif.wave_vpp   = vpp_q;
    assign mif.sig_lost   = lost_q;
    assign mif.meas_valid = valid_q;

`ifdef MEAS_DUTY_EN
    logic [CNT_W-1:0] acc_duty, nxt_duty, duty_q;

    // Samples that leave the detector in HI, saturating
    always_comb begin
        nxt_duty = acc_duty;
        if (smp_acc && det_now == DET_HI && acc_duty != '1) nxt_duty = acc_duty + CNT_W'(1);
    end

    // Duty accumulator and its latched result, same window timing as the others
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            acc_duty <= '0;
            duty_q   <= '0;
        end else begin
            acc_duty <= (!mif.meas_en || win_end) ? '0 : nxt_duty;
            if (win_end) duty_q <= nxt_duty;
        end
    end

    assign mif.duty_cnt = duty_q;
`else
    logic det_unused;
    assign det_unused   = (det_now == DET_HI);
    assign mif.duty_cnt = '0;
`endif

endmodule
